// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU control interface: the 4-bit ALU control
// codes, the R-type funct codes the issue block understands, the issue FSM
// state type and a reference ALU function used by the optional self-checker.
// No ports (package).
// ----------------------------------------------------------------------------
package alu_pkg;

    // ALU control codes as seen on alu_ctrl
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1101;

    // R-type funct codes
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_NAND = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } issue_state_e;

    // Reference result of the ALU for a given control code; SLT is signed.
    function automatic logic [31:0] alu_ref(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [3:0]  ctrl);
        logic [31:0] r;
        r = '0;
        case (ctrl)
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
            ALU_NOR:  r = ~(a | b);
            ALU_NAND: r = ~(a & b);
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// ----------------------------------------------------------------------------
// alu_issue_dec
// Combinational R-type funct decoder for the ALU control interface.
// Ports:
//   funct       in  6  R-type funct code
//   ctrl        out 4  ALU control code (0000 for unsupported functs)
//   unsupported out 1  funct code is not one the ALU implements
// ----------------------------------------------------------------------------
module alu_issue_dec
    import alu_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] ctrl,
    output logic       unsupported
);

    always_comb begin
        ctrl        = ALU_AND;
        unsupported = 1'b0;
        case (funct)
            FUNCT_AND:  ctrl = ALU_AND;
            FUNCT_OR:   ctrl = ALU_OR;
            FUNCT_ADD:  ctrl = ALU_ADD;
            FUNCT_SUB:  ctrl = ALU_SUB;
            FUNCT_SLT:  ctrl = ALU_SLT;
            FUNCT_NOR:  ctrl = ALU_NOR;
            FUNCT_NAND: ctrl = ALU_NAND;
            default: begin
                ctrl        = ALU_AND;
                unsupported = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ----------------------------------------------------------------------------
// alu_issue
// Sequencer in front of the 32-bit ALU. Accepts an R-type request
// (funct, a, b) on a valid/ready channel, drives registered operands and
// control code to the ALU, captures result and flags one cycle later and
// returns them on a valid/ready response channel. Three-state FSM:
// IDLE -> EXEC -> RESP -> IDLE, so at most one op every three cycles.
//
// Optional feature: define ALU_ISSUE_CHECK_EN to add an inline reference
// checker and the sticky chk_fail output.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   req_valid/req_ready              request handshake
//   req_funct, req_a, req_b          request payload
//   resp_valid/resp_ready            response handshake
//   resp_result, resp_zero,
//   resp_cout, resp_ovf, resp_err    response payload
//   alu_rst_n                        ~rst to the ALU
//   alu_src1, alu_src2, alu_ctrl     registered ALU operands / control
//   alu_result, alu_zero,
//   alu_cout, alu_ovf                ALU outputs
//   op_count                         completed responses (wrapping)
//   chk_fail                         sticky checker mismatch (macro only)
// ----------------------------------------------------------------------------
module alu_issue
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_funct,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_result,
    output logic             resp_zero,
    output logic             resp_cout,
    output logic             resp_ovf,
    output logic             resp_err,
    output logic             alu_rst_n,
    output logic [31:0]      alu_src1,
    output logic [31:0]      alu_src2,
    output logic [3:0]       alu_ctrl,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_cout,
    input  logic             alu_ovf,
    output logic [CNT_W-1:0] op_count
`ifdef ALU_ISSUE_CHECK_EN
    ,
    output logic             chk_fail
`endif
);

    issue_state_e     state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_result_q, resp_result_d;
    logic             resp_zero_q, resp_zero_d;
    logic             resp_cout_q, resp_cout_d;
    logic             resp_ovf_q, resp_ovf_d;
    logic             resp_err_q, resp_err_d;
    logic [31:0]      src1_q, src1_d;
    logic [31:0]      src2_q, src2_d;
    logic [3:0]       ctrl_q, ctrl_d;
    // Remembers that the op in flight was unsupported until it is captured
    logic             unsup_q, unsup_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic [3:0]       dec_ctrl;
    logic             dec_unsup;

    alu_issue_dec u_dec (
        .funct       (req_funct),
        .ctrl        (dec_ctrl),
        .unsupported (dec_unsup)
    );

`ifdef ALU_ISSUE_CHECK_EN
    logic chk_fail_q, chk_fail_d;
    logic chk_mismatch;

    // Reference compare against the registered operands while the ALU is settled
    always_comb begin
        chk_mismatch = (state_q == ST_EXEC) && !unsup_q &&
                       (alu_result != alu_ref(src1_q, src2_q, ctrl_q));
        chk_fail_d   = chk_fail_q | chk_mismatch;
    end

    assign chk_fail = chk_fail_q;
`endif

    // Next-state logic: load operands in IDLE, capture ALU outputs in EXEC,
    // release the response in RESP once the consumer takes it.
    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_zero_d   = resp_zero_q;
        resp_cout_d   = resp_cout_q;
        resp_ovf_d    = resp_ovf_q;
        resp_err_d    = resp_err_q;
        src1_d        = src1_q;
        src2_d        = src2_q;
        ctrl_d        = ctrl_q;
        unsup_d       = unsup_q;
        op_count_d    = op_count_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    src1_d      = req_a;
                    src2_d      = req_b;
                    ctrl_d      = dec_ctrl;
                    unsup_d     = dec_unsup;
                    req_ready_d = 1'b0;
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Unsupported ops report an error with an all-zero payload
                resp_result_d = unsup_q ? 32'd0 : alu_result;
                resp_zero_d   = unsup_q ? 1'b0  : alu_zero;
                resp_cout_d   = unsup_q ? 1'b0  : alu_cout;
                resp_ovf_d    = unsup_q ? 1'b0  : alu_ovf;
                resp_err_d    = unsup_q;
                resp_valid_d  = 1'b1;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    op_count_d   = op_count_q + CNT_W'(1);
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // Single state register for the FSM and all its registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
            resp_cout_q   <= 1'b0;
            resp_ovf_q    <= 1'b0;
            resp_err_q    <= 1'b0;
            src1_q        <= '0;
            src2_q        <= '0;
            ctrl_q        <= ALU_AND;
            unsup_q       <= 1'b0;
            op_count_q    <= '0;
`ifdef ALU_ISSUE_CHECK_EN
            chk_fail_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_zero_q   <= resp_zero_d;
            resp_cout_q   <= resp_cout_d;
            resp_ovf_q    <= resp_ovf_d;
            resp_err_q    <= resp_err_d;
            src1_q        <= src1_d;
            src2_q        <= src2_d;
            ctrl_q        <= ctrl_d;
            unsup_q       <= unsup_d;
            op_count_q    <= op_count_d;
`ifdef ALU_ISSUE_CHECK_EN
            chk_fail_q    <= chk_fail_d;
`endif
        end
    end

    assign alu_rst_n   = ~rst;
    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_zero   = resp_zero_q;
    assign resp_cout   = resp_cout_q;
    assign resp_ovf    = resp_ovf_q;
    assign resp_err    = resp_err_q;
    assign alu_src1    = src1_q;
    assign alu_src2    = src2_q;
    assign alu_ctrl    = ctrl_q;
    assign op_count    = op_count_q;

endmodule
